// File: rtl/face_detect_mul_arbiter.sv
// Round-robin share of one 3-stage 13s x 16u multiplier; result LATENCY cycles after transfer; res_ready low on a valid result freezes the pipe via mul_ce.
// Optional perf counters under FACE_DETECT_MUL_ARB_PERF_EN.
module face_detect_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*13-1:0] req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    output logic                  mul_ce,
    output logic [12:0]           mul_din0,
    output logic [15:0]           mul_din1,
    input  logic [28:0]           mul_dout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [28:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic [31:0]           perf_grants,
    output logic [31:0]           perf_stalls
);

    logic [ID_W-1:0]    r_rr_ptr;
    logic [LATENCY-1:0] r_vld;
    logic [ID_W-1:0]    r_id [LATENCY];
    logic [12:0]        r_last_a;
    logic [15:0]        r_last_b;

    logic               w_ce;
    logic               w_any;
    logic               w_xfer;
    logic [ID_W-1:0]    w_gidx;
    logic [ID_W-1:0]    w_cand;
    logic [12:0]        w_sel_a;
    logic [15:0]        w_sel_b;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_gidx = w_cand;
            end
        end
    end

    assign w_ce    = ~r_vld[LATENCY-1] | res_ready;
    assign w_xfer  = w_any & w_ce;
    assign w_sel_a = req_a[13*w_gidx +: 13];
    assign w_sel_b = req_b[16*w_gidx +: 16];

    assign mul_ce    = w_ce;
    assign req_ready = w_xfer ? (NUM_REQ'(1) << w_gidx) : '0;
    assign mul_din0  = w_any ? w_sel_a : r_last_a;
    assign mul_din1  = w_any ? w_sel_b : r_last_b;
    assign res_valid = r_vld[LATENCY-1];
    assign res_id    = r_id[LATENCY-1];
    assign res_data  = mul_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_vld    <= '0;
            r_last_a <= '0;
            r_last_b <= '0;
            for (int k = 0; k < LATENCY; k++) r_id[k] <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
                r_last_a <= w_sel_a;
                r_last_b <= w_sel_b;
            end
            // Shadow pipe moves in lockstep with the multiplier's ce.
            if (w_ce) begin
                r_vld[0] <= w_xfer;
                r_id[0]  <= w_gidx;
                for (int k = 1; k < LATENCY; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    r_id[k]  <= r_id[k-1];
                end
            end
        end
    end

`ifdef FACE_DETECT_MUL_ARB_PERF_EN
    logic [31:0] r_perf_grants;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_grants <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_xfer) r_perf_grants <= r_perf_grants + 32'd1;
            if (!w_ce)  r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_grants = r_perf_grants;
    assign perf_stalls = r_perf_stalls;
`else
    assign perf_grants = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_face_detect_mul_arbiter.sv
// Bench for face_detect_mul_arbiter with a behavioural 3-stage multiplier, scoreboard and pointer model.
module tb_face_detect_mul_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*13-1:0] req_a;
    logic [N*16-1:0] req_b;
    logic          mul_ce;
    logic [12:0]   mul_din0;
    logic [15:0]   mul_din1;
    logic [28:0]   mul_dout;
    logic          res_valid, res_ready;
    logic [28:0]   res_data;
    logic [1:0]    res_id;
    logic [31:0]   perf_grants, perf_stalls;

    always #5 clk = ~clk;

    face_detect_mul_arbiter #(.NUM_REQ(N), .ID_W(2), .LATENCY(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_ce(mul_ce), .mul_din0(mul_din0),
        .mul_din1(mul_din1), .mul_dout(mul_dout), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .perf_grants(perf_grants), .perf_stalls(perf_stalls)
    );

    function automatic logic [28:0] prod(input logic [12:0] a, input logic [15:0] b);
        int ia, ib;
        ia = int'($signed(a));
        ib = int'(b);
        return 29'(ia * ib);
    endfunction

    // Behavioural multiplier: three ce-qualified stages, no reset.
    logic [28:0] m_st [3];
    always @(posedge clk) begin
        if (mul_ce) begin
            m_st[0] <= prod(mul_din0, mul_din1);
            m_st[1] <= m_st[0];
            m_st[2] <= m_st[1];
        end
    end
    assign mul_dout = m_st[2];

    logic [N-1:0] v_q;
    logic [12:0]  a_q [N];
    logic [15:0]  b_q [N];
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[13*i +: 13] = a_q[i];
            req_b[16*i +: 16] = b_q[i];
        end
    end
    assign req_valid = v_q;

    typedef struct { logic [1:0] id; logic [28:0] data; } exp_t;
    exp_t sb[$];

    int n_pass = 0, n_total = 0;
    int m_ptr;
    logic [N-1:0] acc;
    logic prev_stall;
    logic [28:0] prev_data;
    logic [1:0] prev_id;
    logic rr_chk;
    int rr_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        v_q = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_ptr = 0;
        acc = '0;
        prev_stall = 1'b0;
    endtask

    // vmode: 0 random, 1 all valid, 2 none, 3 req0 only. rmode: 0 random, 1 ready, 2 not ready.
    task automatic run_cycles(input int n, input int vmode, input int rmode);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                if (vmode == 2) v_q[i] = 1'b0;
                else if (!(v_q[i] && !acc[i])) begin
                    a_q[i] = 13'($urandom);
                    b_q[i] = 16'($urandom);
                    case (vmode)
                        0: v_q[i] = ($urandom_range(0, 1) == 1);
                        1: v_q[i] = 1'b1;
                        default: v_q[i] = (i == 0);
                    endcase
                end
            end
            res_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
            @(negedge clk);
            begin
                logic stall;
                logic [N-1:0] exp_rdy;
                int g;
                stall = res_valid & ~res_ready;
                g = pick(v_q, m_ptr);
                exp_rdy = (stall || g < 0) ? '0 : (N'(1) << g);
                chk("mul_ce", 32'(mul_ce), 32'(!stall));
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (stall && prev_stall) begin
                    chk("stall_hold_data", 32'(res_data), 32'(prev_data));
                    chk("stall_hold_id", 32'(res_id), 32'(prev_id));
                end
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) chk("res_valid_unexpected", 32'(res_valid), 32'd0);
                    else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("res_data", 32'(res_data), 32'(e.data));
                        chk("res_id", 32'(res_id), 32'(e.id));
                    end
                end
                if (exp_rdy != 0) begin
                    if (rr_chk) begin
                        chk("rr_order", 32'(g), 32'(rr_cnt % N));
                        rr_cnt++;
                    end
                    sb.push_back('{id: 2'(g), data: prod(a_q[g], b_q[g])});
                    m_ptr = (g + 1) % N;
                end
                acc = exp_rdy;
                prev_stall = stall;
                prev_data = res_data;
                prev_id = res_id;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct { int req; logic [12:0] a; logic [15:0] b; logic [28:0] exp; } vec_t;
    vec_t vt [6];

    initial begin
        int lat;
        vt[0] = '{0, 13'h1FFF, 16'hFFFF, 29'h1FFF0001};
        vt[1] = '{2, 13'h1000, 16'hFFFF, 29'h10001000};
        vt[2] = '{2, 13'h0FFF, 16'hFFFF, 29'h0FFEF001};
        vt[3] = '{1, 13'h0000, 16'h1234, 29'h00000000};
        vt[4] = '{3, 13'h0001, 16'h0001, 29'h00000001};
        vt[5] = '{1, 13'h1FFF, 16'h0001, 29'h1FFFFFFF};
        rr_chk = 1'b0; rr_cnt = 0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin a_q[i] = '0; b_q[i] = '0; end
        @(posedge clk); #1;
        do_reset();

        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_mul_ce", 32'(mul_ce), 32'd1);
        chk("rst_perf_grants", perf_grants, 32'd0);
        chk("rst_perf_stalls", perf_stalls, 32'd0);
        @(posedge clk); #1;

        // Single-requester vectors with latency measurement.
        for (int t = 0; t < 6; t++) begin
            v_q = N'(1) << vt[t].req;
            a_q[vt[t].req] = vt[t].a;
            b_q[vt[t].req] = vt[t].b;
            res_ready = 1'b1;
            @(negedge clk);
            chk("vec_ready", 32'(req_ready), 32'(N'(1) << vt[t].req));
            @(posedge clk); #1;
            v_q = '0;
            lat = 1;
            while (!res_valid && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("vec_latency", 32'(lat), 32'd3);
            chk("vec_data", 32'(res_data), 32'(vt[t].exp));
            chk("vec_id", 32'(res_id), 32'(vt[t].req));
        end
        @(posedge clk); #1;

        // Round-robin order, then stall on a full pipe and drain.
        do_reset();
        rr_chk = 1'b1; rr_cnt = 0;
        run_cycles(12, 1, 1);
        rr_chk = 1'b0;
        run_cycles(5, 1, 2);
        chk("stall_inflight", 32'(sb.size()), 32'd3);
        run_cycles(6, 2, 1);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        // Reset with products in flight.
        run_cycles(6, 1, 1);
        do_reset();
        v_q = 4'b1010;
        res_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h2);
        chk("post_rst_valid0", 32'(res_valid), 32'd0);
        sb.push_back('{id: 2'd1, data: prod(a_q[1], b_q[1])});
        m_ptr = 2;
        @(posedge clk); #1;
        v_q = '0;
        @(negedge clk);
        chk("post_rst_valid1", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_valid2", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        run_cycles(5, 2, 1);
        chk("post_rst_empty", 32'(sb.size()), 32'd0);

        // Randomized traffic against the scoreboard.
        run_cycles(2000, 0, 0);
        run_cycles(10, 2, 1);
        chk("rand_empty", 32'(sb.size()), 32'd0);

        // Perf counters: 10 transfers, 5 stall cycles.
        do_reset();
        run_cycles(10, 3, 1);
        run_cycles(5, 2, 2);
        run_cycles(4, 2, 1);
        chk("perf_empty", 32'(sb.size()), 32'd0);
`ifdef FACE_DETECT_MUL_ARB_PERF_EN
        chk("perf_grants", perf_grants, 32'd10);
        chk("perf_stalls", perf_stalls, 32'd5);
`else
        chk("perf_grants_off", perf_grants, 32'd0);
        chk("perf_stalls_off", perf_stalls, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/face_detect_mul_arbiter.md
# face_detect_mul_arbiter

Round-robin arbiter that shares one pipelined signed×unsigned multiplier (13-bit signed × 16-bit unsigned → 29-bit signed, `face_detect_mul_mul_13s_16ns_29_4_1`) among several requesters in the face-detection accelerator. It drives the multiplier's `ce`, `din0` and `din1`, and returns `dout` on a result channel. A valid/tag shadow pipeline tracks each in-flight product, because the multiplier itself carries no valid signal. Backpressure on the result channel stalls the whole multiplier through `ce`.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester tag width, equal to `$clog2(NUM_REQ)`.
- `LATENCY`, 3: number of ce-qualified register stages from `din0`/`din1` to `dout`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester operand valid.
- `req_ready` out NUM_REQ: per-requester accept; one-hot or zero.
- `req_a` in NUM_REQ*13: signed operands, requester i at `[13*i +: 13]`.
- `req_b` in NUM_REQ*16: unsigned operands, requester i at `[16*i +: 16]`.
- `mul_ce` out 1: multiplier clock enable.
- `mul_din0` out 13: to multiplier `din0`.
- `mul_din1` out 16: to multiplier `din1`.
- `mul_dout` in 29: from multiplier `dout`.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer ready.
- `res_data` out 29: signed product, equal to `mul_dout`.
- `res_id` out ID_W: requester that issued this product.
- `perf_grants` out 32: accepted-operation counter (FACE_DETECT_MUL_ARB_PERF_EN only).
- `perf_stalls` out 32: stall-cycle counter (FACE_DETECT_MUL_ARB_PERF_EN only).

## Operation
- State:
  - `rr_ptr` (ID_W bits): highest-priority requester.
  - `vld_pipe[LATENCY]` and `id_pipe[LATENCY]`: shadow of the multiplier stages.
- Stall rule: `mul_ce = ~vld_pipe[LATENCY-1] | res_ready`.
  - When `mul_ce` = 0, `vld_pipe`, `id_pipe` and the multiplier all hold.
- Arbitration is combinational.
  - Search starts at `rr_ptr` and wraps modulo NUM_REQ. The first i with `req_valid[i]` is granted.
  - `req_ready[i] = grant[i] & mul_ce`.
- Transfer occurs when `req_valid[i] & req_ready[i]`.
  - `mul_din0`/`mul_din1` are muxed from the granted requester.
  - When there is no grant, they hold the previously issued operands. Those operands are don't-care because they are masked by `vld_pipe`.
- On each cycle with `mul_ce` = 1:
  - `vld_pipe` and `id_pipe` shift by one.
  - Stage 0 loads `transfer` and the granted index.
- Pointer update: on transfer, `rr_ptr <= (grant_idx + 1) mod NUM_REQ`. Otherwise it holds.
  - Wrap from NUM_REQ-1 goes to 0. This holds for non-power-of-two NUM_REQ too.
- Outputs:
  - `res_valid = vld_pipe[LATENCY-1]`
  - `res_id = id_pipe[LATENCY-1]`
  - `res_data = mul_dout`
- Arithmetic: product = `$signed(a) * $signed({1'b0,b})`. It is exact in 29 bits, with no saturation and no truncation.
- Requester obligation: `req_a`/`req_b` must be held stable while `req_valid` is high and `req_ready` is low.

## Timing
- Reset values:
  - `vld_pipe` = 0, `id_pipe` = 0, `rr_ptr` = 0, perf counters = 0.
  - `res_valid` = 0, `res_id` = 0, `mul_ce` = 1.
- Reset mid-operation: all in-flight products are discarded. The multiplier's internal registers are not reset; `vld_pipe` masks them.
- Latency: a transfer in cycle T gives `res_valid` in cycle T+LATENCY if there is no stall.
- Throughput: one operation per cycle while `res_ready` = 1.
- Stall: when `res_valid` = 1 and `res_ready` = 0, `mul_ce` = 0, `req_ready` = 0, and `res_data`/`res_id` hold.
- No bubble cost: when `vld_pipe[LATENCY-1]` = 0, the pipe advances regardless of `res_ready`.
- Simultaneous events:
  - Result accept and new transfer in the same cycle are both allowed.
  - Several requesters valid at once: exactly one is granted.

## Configuration
- `FACE_DETECT_MUL_ARB_PERF_EN` defined:
  - `perf_grants` increments on each transfer.
  - `perf_stalls` increments on each cycle with `mul_ce` = 0.
  - Both wrap at 2^32 and clear on `reset`.
- Not defined: `perf_grants` and `perf_stalls` are tied to 0 and no counter logic is instantiated.

## Test plan
- Req0 only, a=13'h1FFF (−1), b=16'hFFFF, `res_ready` = 1 → `res_valid` rises 3 cycles after transfer with `res_data` = 29'h1FFF0001 and `res_id` = 0.
- Req2, a=−4096, b=65535 → `res_data` = 29'h10001000 and `res_id` = 2. Also a=4095, b=65535 → 29'h0FFEF001.
- All 4 requesters valid continuously, `res_ready` = 1 → grants follow 0,1,2,3,0,…, one per cycle; `res_id` follows the same order delayed by 3 cycles; `req_ready` is always one-hot.
- Full pipe, `res_ready` low for 5 cycles → `mul_ce` = 0, `req_ready` = 0, `res_data`/`res_id` stable. After release, 3 queued results drain in order with no loss or duplication.
- `reset` asserted for 1 cycle with 3 products in flight → no `res_valid` for the next 3 cycles, `rr_ptr` = 0, and the next grant goes to the lowest-index valid requester.
- With PERF_EN defined: 10 transfers and 5 stall cycles → `perf_grants` = 10 and `perf_stalls` = 5. Without PERF_EN: both read 0.
